// File: rtl/seq_step_counter.sv
// -----------------------------------------------------------------------------
// seq_step_counter
//
// Sequence-address counter for the Genius game datapath. A pass starts with
// `start`, which latches the pass limit from `data`. Each cycle with `E` high
// moves the sequence address one position forward, until the address equals
// the latched limit. The block then reports terminal count (`tc`) and bumps a
// saturating count of completed passes (`level`). A zero limit completes the
// pass straight away, without entering COUNT.
//
// Parameters:
//   WIDTH     - width of the sequence address, the limit and SEQFPGA
//   LEVEL_W   - width of the completed-pass counter
//   MAX_LEVEL - saturation value of level (must be <= 2**LEVEL_W-1)
//
// Ports:
//   clk      in   system clock; all state changes on the rising edge
//   R        in   synchronous reset, active-high, overrides every other input
//   start    in   begin a new pass (ignored while a pass is counting)
//   E        in   step enable; only acted on in COUNT
//   data     in   pass limit, sampled only when a start is accepted
//   SEQFPGA  out  current sequence address (registered)
//   tc       out  terminal count (registered)
//   busy     out  high while counting (registered)
//   level    out  completed passes since reset, saturating (registered)
//
// Build option:
//   SEQ_STEP_TC_PULSE_EN - when defined, tc is a one-cycle pulse on entry to
//                          DONE. When undefined (the default), tc stays high
//                          for the whole time the block sits in DONE.
// -----------------------------------------------------------------------------
module seq_step_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned MAX_LEVEL = 15
) (
  input  logic               clk,
  input  logic               R,
  input  logic               start,
  input  logic               E,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   SEQFPGA,
  output logic               tc,
  output logic               busy,
  output logic [LEVEL_W-1:0] level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lim_q, lim_d;
  logic [WIDTH-1:0]   addr_d;
  logic               tc_d;
  logic               busy_d;
  logic [LEVEL_W-1:0] level_d;

  logic [WIDTH-1:0]   addr_inc;
  logic [LEVEL_W-1:0] level_inc;

  // The address wraps within WIDTH bits by construction. It can never
  // actually wrap, because counting stops at lim_q.
  assign addr_inc  = SEQFPGA + WIDTH'(1);
  // Saturating increment of the completed-pass count.
  assign level_inc = (level >= LEVEL_W'(MAX_LEVEL)) ? level : level + LEVEL_W'(1);

  // Next-state and next-output logic.
  // NOTE: every signal gets a default at the top of the block. Otherwise a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    addr_d  = SEQFPGA;
    tc_d    = tc;
    level_d = level;

    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        tc_d   = 1'b0;
      end

      COUNT: begin
        // start is deliberately ignored here. A pass cannot be restarted
        // part-way, and data is not re-latched.
        if (E) begin
          addr_d = addr_inc;
          // Compare against the incremented value. tc then rises in the same
          // cycle that SEQFPGA first shows the limit.
          if (addr_inc == lim_q) begin
            state_d = DONE;
            tc_d    = 1'b1;
            level_d = level_inc;
          end
        end
      end

      DONE: begin
`ifdef SEQ_STEP_TC_PULSE_EN
        tc_d = 1'b0;
`endif
      end

      default: state_d = IDLE;
    endcase

    // An accepted start (from IDLE or DONE) overrides the per-state defaults
    // above.
    if (start && (state_q != COUNT)) begin
      lim_d  = data;
      addr_d = '0;
      if (data == '0) begin
        state_d = DONE;
        tc_d    = 1'b1;
        level_d = level_inc;
      end else begin
        state_d = COUNT;
        tc_d    = 1'b0;
      end
    end

    busy_d = (state_d == COUNT);
  end

  // State and output registers. R is synchronous and has priority over all
  // other inputs.
  // NOTE: sequential state uses non-blocking (<=) assignments. All registers
  // then update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      lim_q   <= '0;
      SEQFPGA <= '0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      level   <= '0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      SEQFPGA <= addr_d;
      tc      <= tc_d;
      busy    <= busy_d;
      level   <= level_d;
    end
  end

endmodule

// File: doc/seq_step_counter.md
Name: seq_step_counter

Overview:
- Parametrised sequence-address counter for the Genius game datapath. It steps the ROM/sequence address one position per enable, up to a run-time limit (the current round length).
- Signals completion via tc and tracks completed passes in a saturating level counter.
- Successor of the 4-bit FPGA sequence counter. Adds width parameters, a start/limit latch, an explicit FSM, busy status, a level counter and a defined limit==0 case.

Parameters:
- WIDTH, 4, width of sequence address, limit and SEQFPGA.
- LEVEL_W, 4, width of the completed-pass counter.
- MAX_LEVEL, 15, saturation value of level; must be <= 2^LEVEL_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- R  input  1  synchronous reset, active-high.
- start  input  1  begin a new pass; limit is latched on this edge.
- E  input  1  step enable; one increment per cycle while high in COUNT.
- data  input  WIDTH  pass limit (number of steps); sampled only on an accepted start.
- SEQFPGA  output  WIDTH  current sequence address (registered).
- tc  output  1  terminal count (pass complete).
- busy  output  1  high while in COUNT.
- level  output  LEVEL_W  number of completed passes since reset, saturating.

Behaviour:
- Single clock clk. R is synchronous, active-high, and has priority over all other inputs.
- Reset values: state=IDLE, SEQFPGA=0, tc=0, busy=0, level=0, lim_q=0.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - SEQFPGA=0, tc=0, busy=0.
  - start=1: lim_q<=data, SEQFPGA<=0.
  - If data==0: go to DONE next edge (tc=1, level+1). Otherwise go to COUNT (busy=1).
  - E is ignored in IDLE, including on the start cycle.
- COUNT:
  - E=1: SEQFPGA<=SEQFPGA+1 (WIDTH-bit).
  - If SEQFPGA+1==lim_q, on the same edge: state<=DONE, tc<=1, busy<=0, level<=min(level+1, MAX_LEVEL). tc therefore goes high in the same cycle SEQFPGA first equals lim_q.
  - E=0: hold all state.
  - start is ignored in COUNT; no restart mid-pass and data is not re-latched.
- DONE:
  - SEQFPGA holds at lim_q; busy=0.
  - tc behaviour per the Optional Feature.
  - E is ignored; no further increments and no wrap.
  - start=1: behaves as start from IDLE (relatch data, SEQFPGA<=0, tc<=0, go to COUNT, or back to DONE if data==0).
- Wrap-around: cannot occur. The maximum reachable SEQFPGA is lim_q <= 2^WIDTH-1, and lim_q==0 never enters COUNT.
- Level saturation: level stays at MAX_LEVEL on further completions; no wrap.
- Reset mid-operation (R=1 in any state, any cycle): all registers return to their reset values on that edge. start or E asserted in the same cycle are discarded.
- data changes after an accepted start have no effect on the current pass.

Optional Feature:
- Macro: SEQ_STEP_TC_PULSE_EN.
- Defined: tc is a one-cycle pulse on the edge entering DONE and returns to 0 the following cycle while the block remains in DONE.
- Undefined (default): tc is a level, high for the whole time in DONE, cleared only by R or an accepted start.
- level, busy and SEQFPGA behaviour is identical in both builds.

Test Plan:
- Reset defaults: R=1 for 2 cycles with start=1, E=1, data=4'h5 -> SEQFPGA=0, tc=0, busy=0, level=0 throughout and on the first cycle after R drops.
- Basic pass, WIDTH=4: start with data=3, then E=1 continuously -> SEQFPGA reads 1, 2, 3 on successive cycles; tc=1 and busy=0 in the cycle SEQFPGA=3; level=1. SEQFPGA stays 3 with further E.
- Gapped enable and ignored inputs: start with data=4; E pattern 1,0,1,1,0,1; change data to 9 and pulse start mid-pass -> SEQFPGA reaches 4 only after the 4th E=1; limit stays 4; start has no effect.
- Zero limit and saturation: start with data=0 -> DONE next cycle, tc=1, SEQFPGA=0, level+1. Repeat 17 passes -> level stops at 15.
- Reset mid-pass: data=8, 5 steps taken (SEQFPGA=5), assert R for one cycle together with E=1 -> next cycle SEQFPGA=0, state IDLE, level=0, tc=0.
- Macro build check: data=2, run to DONE and hold 3 cycles -> with SEQ_STEP_TC_PULSE_EN, tc high for exactly 1 cycle; without it, tc high for all 3 cycles until start.
